// File: rtl/vad_gate_buffer.sv
// vad_gate_buffer: circular audio buffer that replays VAD pre-roll then live audio.
// Ports: clk/rst, audio_in+sample_valid, VAD pulse/level, out_* stream, status; macro GATE_TIMESTAMP_EN adds out_timestamp.
module vad_gate_buffer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 13,
  parameter int PREROLL_SAMPLES = 4800
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] audio_in,
  input  logic              sample_valid,
  input  logic              pre_trigger_pulse,
  input  logic              speech_detected,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_first,
  output logic              out_last,
  output logic              segment_active,
  output logic              overflow,
  output logic [ADDR_W:0]   occupancy
`ifdef GATE_TIMESTAMP_EN
  ,
  output logic [31:0]       out_timestamp
`endif
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int PW = ADDR_W + 1;
  localparam logic [PW-1:0] ONE = PW'(1);
  localparam logic [PW-1:0] FULL = PW'(DEPTH - 1);
  localparam logic [PW-1:0] PRE = PW'(PREROLL_SAMPLES);
  localparam logic [ADDR_W-1:0] HMAX = '1;
  localparam logic [ADDR_W-1:0] H1 = ADDR_W'(1);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, end_ptr;
  logic [PW-1:0] occ, wr_nxt, hist_ext, pre_len;
  logic [ADDR_W-1:0] hist_cnt;
  logic first_pending, trig_pending, last_issued;
  logic s1_valid, s1_first, s1_last;
  logic [DATA_W-1:0] s1_data;
  logic wr_en, adv, room, drain_empty, fire, ovr;
  logic zero_len, pend_now, rd_en, issue_last;

  assign wr_en = sample_valid;
  assign wr_nxt = wr_en ? wr_ptr + ONE : wr_ptr;
  assign occ = wr_ptr - rd_ptr;
  assign occupancy = occ;
  assign hist_ext = {1'b0, hist_cnt};
  assign pre_len = (hist_ext < PRE) ? hist_ext : PRE;
  assign adv = !out_valid || out_ready;
  assign room = !s1_valid || adv;
  assign drain_empty = (rd_ptr == end_ptr);
  assign fire = out_valid && out_ready && out_last;
  assign ovr = (state != IDLE) && wr_en && (occ == FULL);
  // no last beat was ever issued: empty segment or its tail was overrun
  assign zero_len = (state == DRAIN) && drain_empty && !last_issued;
  assign pend_now = trig_pending || pre_trigger_pulse;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (pre_trigger_pulse) state_nxt = STREAM;
      STREAM: if (!speech_detected) state_nxt = DRAIN;
      DRAIN:  if (zero_len || fire)
                state_nxt = pend_now ? STREAM : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One sample is held back while streaming so the final beat is still
  // unread when the end point becomes known and can carry out_last.
  always_comb begin
    rd_en = 1'b0;
    issue_last = 1'b0;
    unique case (state)
      STREAM: rd_en = room && (occ > ONE);
      DRAIN: begin
        rd_en = room && !drain_empty;
        issue_last = rd_en && (rd_ptr + ONE == end_ptr);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[ADDR_W-1:0]] <= audio_in;
    if (rd_en) s1_data <= mem[rd_ptr[ADDR_W-1:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      end_ptr <= '0;
      hist_cnt <= '0;
      first_pending <= 1'b0;
      trig_pending <= 1'b0;
      last_issued <= 1'b0;
      segment_active <= 1'b0;
      overflow <= 1'b0;
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_first <= 1'b0;
      out_last <= 1'b0;
    end else begin
      wr_ptr <= wr_nxt;
      if (wr_en && hist_cnt != HMAX) hist_cnt <= hist_cnt + H1;
      if (state == IDLE)
        rd_ptr <= pre_trigger_pulse ? wr_ptr - pre_len : wr_nxt;
      else if (rd_en || ovr)
        rd_ptr <= rd_ptr + ONE;
      if (state == STREAM && !speech_detected)
        end_ptr <= wr_nxt;
      else if (state == DRAIN && ovr && !rd_en && drain_empty)
        end_ptr <= end_ptr + ONE;
      if (state == IDLE && pre_trigger_pulse)
        first_pending <= 1'b1;
      else if (state == DRAIN && state_nxt == STREAM)
        first_pending <= 1'b1;
      else if (rd_en)
        first_pending <= 1'b0;
      if (state == DRAIN && state_nxt == DRAIN)
        trig_pending <= trig_pending || pre_trigger_pulse;
      else
        trig_pending <= 1'b0;
      if (state_nxt != DRAIN) last_issued <= 1'b0;
      else if (issue_last)    last_issued <= 1'b1;
      if (state == IDLE && pre_trigger_pulse)
        segment_active <= 1'b1;
      else if (state == DRAIN && state_nxt == IDLE)
        segment_active <= 1'b0;
      if (ovr) overflow <= 1'b1;
      if (rd_en) begin
        s1_valid <= 1'b1;
        s1_first <= first_pending;
        s1_last <= issue_last;
      end else if (adv) begin
        s1_valid <= 1'b0;
      end
      if (adv) begin
        out_valid <= s1_valid;
        out_first <= s1_valid && s1_first;
        out_last <= s1_valid && s1_last;
        if (s1_valid) out_data <= s1_data;
      end
    end
  end

`ifdef GATE_TIMESTAMP_EN
  logic [31:0] ts_cnt, s1_ts;

  // index of the sample at rd_ptr = samples written so far minus backlog
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_cnt <= '0;
      s1_ts <= '0;
      out_timestamp <= '0;
    end else begin
      if (wr_en) ts_cnt <= ts_cnt + 32'd1;
      if (rd_en) s1_ts <= ts_cnt - 32'(occ);
      if (adv && s1_valid) out_timestamp <= s1_ts;
    end
  end
`else
  // timestamp path not built
`endif

endmodule

// File: tb/tb_vad_gate_buffer.sv
// tb_vad_gate_buffer: scoreboard bench for vad_gate_buffer.
// Directed segments; a negedge monitor pops expected beats on each handshake.
module tb_vad_gate_buffer;
  localparam int DW = 16;
  localparam int AW = 6;
  localparam int PRE = 16;

  typedef struct packed {
    logic [DW-1:0] d;
    logic f;
    logic l;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [DW-1:0] audio_in = '0;
  logic sample_valid = 1'b0;
  logic pre_trigger_pulse = 1'b0;
  logic speech_detected = 1'b0;
  logic [DW-1:0] out_data;
  logic out_valid;
  logic out_ready;
  logic out_first;
  logic out_last;
  logic segment_active;
  logic overflow;
  logic [AW:0] occupancy;
`ifdef GATE_TIMESTAMP_EN
  logic [31:0] out_timestamp;
`endif

  beat_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int rdy_mode = 1;
  int ramp = 1;

  always #5 clk = ~clk;

  vad_gate_buffer #(
    .DATA_W(DW),
    .ADDR_W(AW),
    .PREROLL_SAMPLES(PRE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .audio_in(audio_in),
    .sample_valid(sample_valid),
    .pre_trigger_pulse(pre_trigger_pulse),
    .speech_detected(speech_detected),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_first(out_first),
    .out_last(out_last),
    .segment_active(segment_active),
    .overflow(overflow),
    .occupancy(occupancy)
`ifdef GATE_TIMESTAMP_EN
    ,
    .out_timestamp(out_timestamp)
`endif
  );

  // ready driver: 0 = held low, 1 = held high, 2 = toggling
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: out_ready = 1'b0;
        1: out_ready = 1'b1;
        default: out_ready = ~out_ready;
      endcase
    end
  end

  // monitor: handshake scoreboard plus hold-stable check under backpressure
  initial begin
    logic pv, pr, pf, pl;
    logic [DW-1:0] pd;
    beat_t e;
    pv = 1'b0; pr = 1'b0; pf = 1'b0; pl = 1'b0; pd = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 1'b0;
      end else begin
        if (pv && !pr) begin
          checks++;
          if (!out_valid || out_data !== pd ||
              out_first !== pf || out_last !== pl) begin
            errors++;
            $display("FAIL hold: got v=%0b d=%0d f=%0b l=%0b need v=1 d=%0d f=%0b l=%0b",
                     out_valid, out_data, out_first, out_last, pd, pf, pl);
          end
        end
        if (out_valid && out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL beat: unexpected d=%0d f=%0b l=%0b need none",
                     out_data, out_first, out_last);
          end else begin
            e = exp_q.pop_front();
            if (out_data !== e.d || out_first !== e.f ||
                out_last !== e.l) begin
              errors++;
              $display("FAIL beat: got d=%0d f=%0b l=%0b need d=%0d f=%0b l=%0b",
                       out_data, out_first, out_last, e.d, e.f, e.l);
            end
          end
        end
        pv = out_valid; pr = out_ready;
        pd = out_data; pf = out_first; pl = out_last;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d need %0d", name, got, want);
    end
  endtask

  task automatic put(input int n);
    repeat (n) begin
      sample_valid = 1'b1;
      audio_in = ramp[DW-1:0];
      ramp++;
      tick();
    end
    sample_valid = 1'b0;
  endtask

  task automatic pulse();
    pre_trigger_pulse = 1'b1;
    tick();
    pre_trigger_pulse = 1'b0;
  endtask

  task automatic push(input int v, input bit f, input bit l);
    beat_t b;
    b.d = v[DW-1:0];
    b.f = f;
    b.l = l;
    exp_q.push_back(b);
  endtask

  task automatic push_range(input int a, input int b);
    for (int v = a; v <= b; v++) push(v, v == a, v == b);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sample_valid = 1'b0;
    pre_trigger_pulse = 1'b0;
    speech_detected = 1'b0;
    rdy_mode = 1;
    tick();
    tick();
    exp_q.delete();
    ramp = 1;
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (segment_active && n < 2000) begin
      tick();
      n++;
    end
    chk({name, " seg_end"}, int'(segment_active), 0);
    repeat (3) tick();
    chk({name, " beats_left"}, exp_q.size(), 0);
  endtask

  initial begin
    // reset state
    do_reset();
    chk("rst out_valid", int'(out_valid), 0);
    chk("rst out_first", int'(out_first), 0);
    chk("rst out_last", int'(out_last), 0);
    chk("rst out_data", int'(out_data), 0);
    chk("rst seg_active", int'(segment_active), 0);
    chk("rst overflow", int'(overflow), 0);
    chk("rst occupancy", int'(occupancy), 0);

    // 1: full pre-roll of 16 then 10 live samples -> 25..50
    put(40);
    chk("t1 idle occ", int'(occupancy), 0);
    speech_detected = 1'b1;
    push_range(25, 50);
    pulse();
    chk("t1 seg_active", int'(segment_active), 1);
    put(10);
    speech_detected = 1'b0;
    tick();
    put(5);
    wait_done("t1");
    chk("t1 overflow", int'(overflow), 0);

    // 2: pre-roll clipped to 5 samples of history -> 1..8
    do_reset();
    put(5);
    speech_detected = 1'b1;
    push_range(1, 8);
    pulse();
    put(3);
    speech_detected = 1'b0;
    tick();
    wait_done("t2");

    // 3: case 1 under toggling ready
    do_reset();
    rdy_mode = 2;
    put(40);
    speech_detected = 1'b1;
    push_range(25, 50);
    pulse();
    put(10);
    speech_detected = 1'b0;
    tick();
    put(5);
    wait_done("t3");

    // 4: stalled reader overrun; beats 1,2 are already in the output
    // pipeline, then the oldest survivor is 80-63+1 = 18
    do_reset();
    rdy_mode = 0;
    speech_detected = 1'b1;
    push(1, 1'b1, 1'b0);
    push(2, 1'b0, 1'b0);
    for (int v = 18; v <= 80; v++) push(v, 1'b0, v == 80);
    pulse();
    put(80);
    chk("t4 overflow", int'(overflow), 1);
    chk("t4 occupancy", int'(occupancy), 63);
    chk("t4 held data", int'(out_data), 1);
    rdy_mode = 1;
    speech_detected = 1'b0;
    tick();
    wait_done("t4");
    chk("t4 overflow sticky", int'(overflow), 1);

    // 5: pulse during DRAIN chains a contiguous second segment
    do_reset();
    put(20);
    rdy_mode = 0;
    speech_detected = 1'b1;
    push_range(5, 25);
    push_range(26, 29);
    pulse();
    put(5);
    speech_detected = 1'b0;
    tick();
    tick();
    speech_detected = 1'b1;
    pulse();
    put(4);
    rdy_mode = 1;
    repeat (10) tick();
    chk("t5 seg_active mid", int'(segment_active), 1);
    speech_detected = 1'b0;
    tick();
    wait_done("t5");

    // 6: asynchronous reset mid-STREAM, then a clean segment
    do_reset();
    rdy_mode = 0;
    put(40);
    speech_detected = 1'b1;
    pulse();
    repeat (4) tick();
    chk("t6 pre out_valid", int'(out_valid), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6 rst out_valid", int'(out_valid), 0);
    chk("t6 rst out_data", int'(out_data), 0);
    chk("t6 rst out_first", int'(out_first), 0);
    chk("t6 rst seg_active", int'(segment_active), 0);
    chk("t6 rst occupancy", int'(occupancy), 0);
    exp_q.delete();
    speech_detected = 1'b0;
    rdy_mode = 1;
    tick();
    rst = 1'b0;
    tick();
    put(3);
    speech_detected = 1'b1;
    push_range(41, 45);
    pulse();
    put(2);
    speech_detected = 1'b0;
    tick();
    wait_done("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
